// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: default geometry, bus widths and the fill state enum.
// Used by the rectangle filler and the framebuffer reader.
package fb_pkg;
    localparam int FB_W_DEF   = 320;
    localparam int FB_H_DEF   = 240;
    localparam int FB_ADDR_W  = 17;
    localparam int FB_COLOR_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FINISH = 2'd2
    } fb_state_e;
endpackage

// File: rtl/fb_addr_calc.sv
// Linear framebuffer address for a 320-pixel-wide buffer: row*320+col built from
// two shifted copies of row, truncated to the framebuffer address width.
module fb_addr_calc
    import fb_pkg::*;
(
    input  logic [8:0]           row,
    input  logic [9:0]           col,
    output logic [FB_ADDR_W-1:0] addr
);
    // 320 = 256 + 64
    assign addr = FB_ADDR_W'({row, 8'b0}) + FB_ADDR_W'({row, 6'b0}) + FB_ADDR_W'(col);
endmodule

// File: rtl/fb_rect_fill.sv
// Solid rectangle filler: one framebuffer write per cycle in raster order, then a done pulse.
// Define FB_CLIP_EN to suppress writes to pixels outside FB_W x FB_H.
module fb_rect_fill
    import fb_pkg::*;
#(
    parameter int FB_W = FB_W_DEF,
    parameter int FB_H = FB_H_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [8:0]            cmd_x,
    input  logic [7:0]            cmd_y,
    input  logic [8:0]            cmd_w,
    input  logic [7:0]            cmd_h,
    input  logic [FB_COLOR_W-1:0] cmd_color,
    output logic                  wr_en,
    output logic [FB_ADDR_W-1:0]  wr_addr,
    output logic [FB_COLOR_W-1:0] wr_data,
    output logic                  done
);
`ifdef FB_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif
    localparam logic [9:0] COL_LIM = 10'(FB_W);
    localparam logic [8:0] ROW_LIM = 9'(FB_H);

    fb_state_e             state_q, state_d;
    logic [9:0]            col_q, col_d, x_q, x_d, x_end_q, x_end_d;
    logic [8:0]            row_q, row_d, y_end_q, y_end_d;
    logic [FB_COLOR_W-1:0] color_q, color_d;
    logic                  wr_en_q, wr_en_d, done_q, done_d;
    logic [FB_ADDR_W-1:0]  wr_addr_q, wr_addr_d, addr_next;
    logic [FB_COLOR_W-1:0] wr_data_q, wr_data_d;
    logic                  fill_next, in_range;

    fb_addr_calc u_addr (
        .row  (row_d),
        .col  (col_d),
        .addr (addr_next)
    );

    // Counters always hold the pixel to be presented on the write port next cycle.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        x_d       = x_q;
        x_end_d   = x_end_q;
        y_end_d   = y_end_q;
        color_d   = color_q;
        fill_next = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    x_d     = {1'b0, cmd_x};
                    x_end_d = {1'b0, cmd_x} + {1'b0, cmd_w} - 10'd1;
                    y_end_d = {1'b0, cmd_y} + {1'b0, cmd_h} - 9'd1;
                    color_d = cmd_color;
                    col_d   = {1'b0, cmd_x};
                    row_d   = {1'b0, cmd_y};
                    if (cmd_w != 9'd0 && cmd_h != 8'd0) begin
                        state_d   = FILL;
                        fill_next = 1'b1;
                    end else begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end
                end
            end
            FILL: begin
                if (col_q == x_end_q) begin
                    if (row_q == y_end_q) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        col_d     = x_q;
                        row_d     = row_q + 9'd1;
                        fill_next = 1'b1;
                    end
                end else begin
                    col_d     = col_q + 10'd1;
                    fill_next = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_range  = (col_d < COL_LIM) && (row_d < ROW_LIM);
        wr_en_d   = fill_next && (!CLIP_EN || in_range);
        wr_addr_d = fill_next ? addr_next : wr_addr_q;
        wr_data_d = fill_next ? color_d : wr_data_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            x_q       <= '0;
            x_end_q   <= '0;
            y_end_q   <= '0;
            color_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            x_q       <= x_d;
            x_end_q   <= x_end_d;
            y_end_q   <= y_end_d;
            color_q   <= color_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = done_q;
endmodule
